// File: rtl/dbus_if_if.sv
// Bus-side signal bundle for dbus_if: registered request fields out, read data and ack back.
interface dbus_if_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );
  modport slave (
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/dbus_if.sv
// MEM-stage to req/ack data bus bridge: one outstanding access, pipeline stall until ack,
// read-data hold until MEM/WB captures, flush discard and wait-state timeout.
module dbus_if #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        timeout_o,
  dbus_if_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t      r_state, w_next;
  logic        r_req, r_we, r_discard, r_timeout;
  logic [3:0]  r_sel;
  logic [31:0] r_addr, r_wdata, r_rd_buf;
  logic [CNT_W-1:0] r_cnt;
  logic        w_start, w_disc, w_tmo;

  assign w_start = cpu_ce_i & ~flush_i;
  // A flush landing on the completion cycle still discards the result.
  assign w_disc  = r_discard | flush_i;
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) & ~bus.bus_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (r_state)
      S_IDLE: begin
        stallreq_o = rst & w_start;
        if (w_start) w_next = S_BUSY;
      end
      S_BUSY: begin
        stallreq_o = r_discard ? cpu_ce_i : 1'b1;
        if (bus.bus_ack_i || w_tmo) w_next = w_disc ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        cpu_data_o = r_rd_buf;
        if (flush_i || !stall_i[4]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_buf  <= '0;
      r_cnt     <= '0;
      r_discard <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_req   <= 1'b1;
          r_we    <= cpu_we_i;
          r_sel   <= cpu_sel_i;
          r_addr  <= cpu_addr_i;
          r_wdata <= cpu_data_i;
          r_cnt   <= '0;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (flush_i) r_discard <= 1'b1;
          if (bus.bus_ack_i || w_tmo) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            if (w_disc) r_discard <= 1'b0;
          end
          if (bus.bus_ack_i) begin
            if (r_we)         r_rd_buf <= '0;
            else if (!w_disc) r_rd_buf <= bus.bus_rdata_i;
          end else if (w_tmo) begin
            r_rd_buf  <= '0;
            r_timeout <= 1'b1;
          end
        end
        S_HOLD: if (flush_i) r_rd_buf <= '0;
        default: ;
      endcase
    end
  end

  assign bus.bus_req_o   = r_req;
  assign bus.bus_we_o    = r_we;
  assign bus.bus_sel_o   = r_sel;
  assign bus.bus_addr_o  = r_addr;
  assign bus.bus_wdata_o = r_wdata;
  assign timeout_o       = r_timeout;

endmodule
